// File: rtl/mssv_seq_tx.sv
// mssv_seq_tx -- framed symbol transmitter with a small request FIFO.
//
// Each accepted request carries the final symbol of a 4-symbol frame.
// Frames are emitted as 000, 110, 000, <req_sym>, followed by GAP_CYCLES
// idle symbols. After each frame a one-cycle done_tx pulse reports the
// result code a downstream detector is expected to produce.
//
// Ports:
//   clk          clock, rising-edge active
//   rst          asynchronous active-high reset
//   req_valid    request strobe
//   req_sym      final symbol of the requested frame
//   req_ready    FIFO not full
//   mssv_tx      registered symbol stream
//   tx_valid     mssv_tx carries a frame symbol
//   tx_last      4th symbol of a frame
//   done_tx      one-cycle pulse after a frame completes
//   expect_code  01 = final symbol even, 10 = odd; held between frames
//   busy         FSM active or FIFO non-empty
//   frame_cnt    completed frame counter, wraps at 256
module mssv_seq_tx #(
    parameter int         FIFO_DEPTH = 2,
    parameter int         GAP_CYCLES = 1,
    parameter logic [2:0] IDLE_SYM   = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_sym,
    output logic       req_ready,
    output logic [2:0] mssv_tx,
    output logic       tx_valid,
    output logic       tx_last,
    output logic       done_tx,
    output logic [1:0] expect_code,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, SYM0, SYM1, SYM2, SYM3, GAP} state_t;

    state_t        state;
    logic [2:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    frame_sym;
    logic [2:0]    gap_cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          frame_end;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = ~full;
    // Full blocks a push even if a pop happens on the same edge.
    assign push      = req_valid & ~full;
    // Points where the FSM may start a new frame.
    assign frame_end = (state == IDLE)
                     | ((state == SYM3) & (GAP_CYCLES == 0))
                     | ((state == GAP) & (gap_cnt == 3'd0));
    assign pop       = frame_end & ~empty;
    assign busy      = (state != IDLE) | ~empty;

    // Request storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_sym;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            frame_sym   <= 3'd0;
            gap_cnt     <= 3'd0;
            mssv_tx     <= IDLE_SYM;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            done_tx     <= 1'b0;
            expect_code <= 2'b00;
            frame_cnt   <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                frame_sym <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Frame completion bookkeeping lands in the cycle after SYM3.
            done_tx <= (state == SYM3);
            if (state == SYM3) begin
                expect_code <= frame_sym[0] ? 2'b10 : 2'b01;
                frame_cnt   <= frame_cnt + 8'd1;
            end

            // Outputs are registered with the state being entered; idle
            // values are the default and frame states override them.
            mssv_tx  <= IDLE_SYM;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;

            case (state)
                SYM0: begin
                    state    <= SYM1;
                    mssv_tx  <= 3'b110;
                    tx_valid <= 1'b1;
                end
                SYM1: begin
                    state    <= SYM2;
                    mssv_tx  <= 3'b000;
                    tx_valid <= 1'b1;
                end
                SYM2: begin
                    state    <= SYM3;
                    mssv_tx  <= frame_sym;
                    tx_valid <= 1'b1;
                    tx_last  <= 1'b1;
                end
                SYM3: begin
                    if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= 3'(GAP_CYCLES - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt != 3'd0) begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A pop always starts a new frame, overriding the IDLE choice.
            if (pop) begin
                state    <= SYM0;
                mssv_tx  <= 3'b000;
                tx_valid <= 1'b1;
                tx_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mssv_seq_tx.sv
// Testbench for mssv_seq_tx. Two instances share clock, reset and request
// inputs: dut_a with one gap cycle, dut_b with no gap. Each is tracked by a
// frame-level reference model; a small sequence detector watches each
// stream and its verdict is compared with expect_code.
module tb_mssv_seq_tx;

    localparam int DEPTH = 2;
    localparam int GA    = 1;
    localparam int GB    = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_sym = 3'd0;

    logic       ready_a, ready_b, valid_a, valid_b, last_a, last_b;
    logic       done_a, done_b, busy_a, busy_b;
    logic [2:0] tx_a, tx_b;
    logic [1:0] code_a, code_b;
    logic [7:0] cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mssv_seq_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GA), .IDLE_SYM(3'b111)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sym(req_sym),
        .req_ready(ready_a), .mssv_tx(tx_a), .tx_valid(valid_a), .tx_last(last_a),
        .done_tx(done_a), .expect_code(code_a), .busy(busy_a), .frame_cnt(cnt_a));

    mssv_seq_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GB), .IDLE_SYM(3'b111)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sym(req_sym),
        .req_ready(ready_b), .mssv_tx(tx_b), .tx_valid(valid_b), .tx_last(last_b),
        .done_tx(done_b), .expect_code(code_b), .busy(busy_b), .frame_cnt(cnt_b));

    wire [17:0] obs_a = {tx_a, valid_a, last_a, done_a, code_a, busy_a, ready_a, cnt_a};
    wire [17:0] obs_b = {tx_b, valid_b, last_b, done_b, code_b, busy_b, ready_b, cnt_b};

    // phase: 0 idle, 1..4 frame symbols, 5.. gap cycles
    typedef struct {
        int              phase;
        logic [3:0][2:0] q;
        int              n;
        logic [2:0]      cur;
        int              cnt;
        logic [1:0]      code;
        bit              done;
    } model_t;

    model_t ma, mb;

    function automatic model_t mreset();
        model_t r;
        r.phase = 0; r.q = '0; r.n = 0; r.cur = 3'd0;
        r.cnt = 0; r.code = 2'b00; r.done = 1'b0;
        return r;
    endfunction

    function automatic model_t mstep(model_t m, int g, bit v, logic [2:0] s);
        model_t r = m;
        bit can_push = (m.n < DEPTH);
        r.done = (m.phase == 4);
        if (r.done) begin
            r.cnt  = (m.cnt + 1) % 256;
            r.code = m.cur[0] ? 2'b10 : 2'b01;
        end
        if (m.phase >= 1 && m.phase <= 3) r.phase = m.phase + 1;
        else if (m.phase >= 4 && m.phase < 4 + g) r.phase = m.phase + 1;
        else if (m.n > 0) begin
            r.cur = m.q[0];
            r.q = m.q >> 3;
            r.n = m.n - 1;
            r.phase = 1;
        end else r.phase = 0;
        if (v && can_push) begin
            r.q[r.n] = s;
            r.n = r.n + 1;
        end
        return r;
    endfunction

    function automatic logic [17:0] exp_vec(model_t m);
        logic [2:0] tx;
        case (m.phase)
            1: tx = 3'b000;
            2: tx = 3'b110;
            3: tx = 3'b000;
            4: tx = m.cur;
            default: tx = 3'b111;
        endcase
        return {tx, (m.phase >= 1 && m.phase <= 4), (m.phase == 4), m.done, m.code,
                (m.phase != 0 || m.n > 0), (m.n < DEPTH), 8'(m.cnt)};
    endfunction

    // Detector: after the 000,110,000 preamble, the next valid symbol
    // classifies the frame (01 even, 10 odd); anything else yields 11.
    logic [8:0] win_a, win_b;
    logic [1:0] det_a, det_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            win_a <= '0; win_b <= '0; det_a <= 2'b00; det_b <= 2'b00;
        end else begin
            if (valid_a) begin
                win_a <= {win_a[5:0], tx_a};
                if (last_a) det_a <= (win_a == 9'b000_110_000) ? (tx_a[0] ? 2'b10 : 2'b01) : 2'b11;
            end
            if (valid_b) begin
                win_b <= {win_b[5:0], tx_b};
                if (last_b) det_b <= (win_b == 9'b000_110_000) ? (tx_b[0] ? 2'b10 : 2'b01) : 2'b11;
            end
        end
    end

    // One clock: inputs applied now, models advanced with them at the edge,
    // outputs sampled 1 time unit after the edge.
    task automatic drive(input bit v, input logic [2:0] s);
        req_valid = v;
        req_sym = s;
        @(posedge clk);
        if (rst) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, GA, v, s);
            mb = mstep(mb, GB, v, s);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 3'd0);
        drive(0, 3'd0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd5);
            vectors++;
            if (obs_a !== 18'b111_0_0_0_00_0_1_00000000) begin
                miscompares++;
                $display("FAIL reset dut_a cyc %0d: got %h want %h", cyc, obs_a, 18'b111_0_0_0_00_0_1_00000000);
            end
            vectors++;
            if (obs_b !== exp_vec(mb)) begin
                miscompares++;
                $display("FAIL reset dut_b cyc %0d: got %h want %h", cyc, obs_b, exp_vec(mb));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single(input logic [2:0] sym, input logic [1:0] want_code);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, sym);
            vectors++;
            if (obs_a !== exp_vec(ma)) begin
                miscompares++;
                $display("FAIL single dut_a cyc %0d: got %h want %h", cyc, obs_a, exp_vec(ma));
            end
            vectors++;
            if (obs_b !== exp_vec(mb)) begin
                miscompares++;
                $display("FAIL single dut_b cyc %0d: got %h want %h", cyc, obs_b, exp_vec(mb));
            end
        end
        vectors++;
        if (code_a !== want_code || cnt_a !== 8'd1) begin
            miscompares++;
            $display("FAIL single_result dut_a: got code %b cnt %0d want code %b cnt 1", code_a, cnt_a, want_code);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        int ndone = 0;
        bit saw_not_ready = 0;
        logic [2:0] seen [$];
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(i < 3, 3'(i + 1));
            if (valid_b) begin nvalid++; seen.push_back(tx_b); end
            if (done_b) ndone++;
            if (!ready_b) saw_not_ready = 1;
            vectors++;
            if (obs_a !== exp_vec(ma)) begin
                miscompares++;
                $display("FAIL b2b dut_a cyc %0d: got %h want %h", cyc, obs_a, exp_vec(ma));
            end
            vectors++;
            if (obs_b !== exp_vec(mb)) begin
                miscompares++;
                $display("FAIL b2b dut_b cyc %0d: got %h want %h", cyc, obs_b, exp_vec(mb));
            end
        end
        vectors++;
        if (nvalid != 12 || ndone != 3 || !saw_not_ready) begin
            miscompares++;
            $display("FAIL b2b_summary dut_b: got valid %0d done %0d notready %0d want 12 3 1", nvalid, ndone, saw_not_ready);
        end
        vectors++;
        if (seen.size() == 12 && (seen[3] !== 3'd1 || seen[7] !== 3'd2 || seen[11] !== 3'd3)) begin
            miscompares++;
            $display("FAIL b2b_order dut_b: got %0d %0d %0d want 1 2 3", seen[3], seen[7], seen[11]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 3'd3);
        drive(1, 3'd4);
        drive(0, 3'd0);
        // both instances are now in SYM1; abort asynchronously
        #1 rst = 1'b1;
        #1;
        ma = mreset();
        mb = mreset();
        vectors++;
        if (obs_a !== exp_vec(ma)) begin
            miscompares++;
            $display("FAIL rst_mid_async dut_a: got %h want %h", obs_a, exp_vec(ma));
        end
        vectors++;
        if (obs_b !== exp_vec(mb)) begin
            miscompares++;
            $display("FAIL rst_mid_async dut_b: got %h want %h", obs_b, exp_vec(mb));
        end
        drive(0, 3'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 3'd0);
            vectors++;
            if (obs_a !== exp_vec(ma) || obs_b !== exp_vec(mb)) begin
                miscompares++;
                $display("FAIL rst_mid_after cyc %0d: got %h %h want %h %h", cyc, obs_a, obs_b, exp_vec(ma), exp_vec(mb));
            end
        end
    endtask

    task automatic test_random_loopback();
        int frames = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom));
            vectors++;
            if (obs_a !== exp_vec(ma)) begin
                miscompares++;
                $display("FAIL random dut_a cyc %0d: got %h want %h", cyc, obs_a, exp_vec(ma));
            end
            vectors++;
            if (obs_b !== exp_vec(mb)) begin
                miscompares++;
                $display("FAIL random dut_b cyc %0d: got %h want %h", cyc, obs_b, exp_vec(mb));
            end
            if (done_a) begin
                vectors++;
                if (code_a !== det_a) begin
                    miscompares++;
                    $display("FAIL loopback dut_a cyc %0d: got %b want %b", cyc, code_a, det_a);
                end
            end
            if (done_b) begin
                frames++;
                vectors++;
                if (code_b !== det_b) begin
                    miscompares++;
                    $display("FAIL loopback dut_b cyc %0d: got %b want %b", cyc, code_b, det_b);
                end
            end
        end
        vectors++;
        if (frames < 50) begin
            miscompares++;
            $display("FAIL loopback_frames: got %0d want at least 50", frames);
        end
    endtask

    task automatic test_wrap();
        int ndone = 0;
        do_reset();
        for (int i = 0; i < 1200 && ndone < 256; i++) begin
            drive(1, 3'($urandom));
            if (done_b) ndone++;
            vectors++;
            if (obs_b !== exp_vec(mb)) begin
                miscompares++;
                $display("FAIL wrap dut_b cyc %0d: got %h want %h", cyc, obs_b, exp_vec(mb));
            end
        end
        vectors++;
        if (ndone != 256 || cnt_b !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_count dut_b: got frames %0d cnt %0d want 256 0", ndone, cnt_b);
        end
    endtask

    initial begin
        ma = mreset();
        mb = mreset();
        test_reset();
        test_single(3'b110, 2'b01);
        test_single(3'b001, 2'b10);
        test_back_to_back();
        test_reset_mid();
        test_random_loopback();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mssv_seq_tx.md
MSSV_SEQ_TX -- requirements
Module: mssv_seq_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, is the number of request entries buffered (legal values 2 and 4).
REQ-002 Parameter GAP_CYCLES, default 1, is the number of idle cycles inserted after each frame (legal range 0..7).
REQ-003 Parameter IDLE_SYM, default 3'b111, is the symbol driven whenever no frame symbol is being sent.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request to send one frame.
REQ-007 req_sym  input  3  final (4th) symbol of the requested frame.
REQ-008 req_ready  output  1  high when the FIFO can accept a request.
REQ-009 mssv_tx  output  3  transmitted symbol stream, registered.
REQ-010 tx_valid  output  1  high while mssv_tx carries a frame symbol.
REQ-011 tx_last  output  1  high with the 4th symbol of a frame.
REQ-012 done_tx  output  1  one-cycle pulse after a frame completes.
REQ-013 expect_code  output  2  result code the receiving detector must produce for the last frame.
REQ-014 busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-015 frame_cnt  output  8  count of completed frames.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high; req_sym is then written to the FIFO.
REQ-017 req_ready SHALL equal NOT full; a pop on the same edge SHALL NOT make a full FIFO accept a request (no bypass).
REQ-018 FSM states SHALL be IDLE, SYM0, SYM1, SYM2, SYM3, GAP.
REQ-019 From IDLE with a non-empty FIFO, the FSM SHALL pop the head entry into a frame register and enter SYM0 on the next edge.
REQ-020 SYM0, SYM1, SYM2 and SYM3 SHALL each last exactly one cycle, in that order, driving mssv_tx = 3'b000, 3'b110, 3'b000 and the frame register respectively, with tx_valid=1.
REQ-021 tx_last SHALL be 1 only in SYM3.
REQ-022 From SYM3, the FSM SHALL go to GAP when GAP_CYCLES>0; otherwise it SHALL go to SYM0 with a pop when the FIFO is non-empty, or to IDLE when it is empty.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, using a 3-bit down-counter, then transition as in REQ-022.
REQ-024 In IDLE and GAP, mssv_tx SHALL be IDLE_SYM and tx_valid and tx_last SHALL be 0.
REQ-025 Latency: a request accepted at edge N into an empty FIFO with the FSM in IDLE SHALL appear as SYM0 in the cycle after edge N+1.
REQ-026 done_tx SHALL pulse for exactly one cycle, in the cycle after SYM3.
REQ-027 expect_code SHALL update with done_tx to 2'b01 if the frame's final symbol is even, or 2'b10 if it is odd, and SHALL hold until the next done_tx.
REQ-028 frame_cnt SHALL increment with each done_tx and wrap from 255 to 0.
REQ-029 With GAP_CYCLES=0 and a non-empty FIFO, frames SHALL be sent back-to-back with no idle symbol between SYM3 and the next SYM0.
REQ-030 The FIFO SHALL preserve request order; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While rst is high, state SHALL be IDLE and the FIFO SHALL be empty, with mssv_tx=IDLE_SYM, tx_valid=0, tx_last=0, done_tx=0, expect_code=2'b00, frame_cnt=0, busy=0 and req_ready=1.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no done_tx, and SHALL discard all queued requests.

Verification
REQ-033 Single request req_sym=3'b110, GAP_CYCLES=1 -> mssv_tx sequence 000,110,000,110 with tx_valid=1, then 111 for 1 cycle; done_tx pulses once; expect_code=01; frame_cnt=1.
REQ-034 Request req_sym=3'b001 -> expect_code=10; tx_last is high only on the 001 symbol.
REQ-035 GAP_CYCLES=0, three requests issued back-to-back -> req_ready drops while the FIFO is full; 12 consecutive valid symbols are sent in request order; 3 done_tx pulses occur.
REQ-036 rst asserted during SYM1 -> next cycle mssv_tx=111, tx_valid=0, no done_tx, FIFO empty, frame_cnt unchanged at its reset value 0.
REQ-037 256 frames sent -> frame_cnt wraps to 0.
REQ-038 Loopback of mssv_tx into the team's 3-bit Mealy sequence detector -> the detector output matches expect_code on every frame.
